// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Brief    : Moore main controller sequencing the shared-memory multi-cycle
//            MIPS datapath (R-format, lw, sw, beq, j) with memory ready stalls.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       retire,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       w_pc_write;
    logic       w_pc_write_cond;
    logic       w_i_or_d;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_mem_to_reg;
    logic       w_reg_dst;
    logic       w_reg_write;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;
    logic [1:0] w_pc_source;
    logic       w_retire;
    logic       w_illegal;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next          = S_FETCH;
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_i_or_d        = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_mem_to_reg    = 1'b0;
        w_reg_dst       = 1'b0;
        w_reg_write     = 1'b0;
        w_alu_src_a     = 1'b0;
        w_alu_src_b     = 2'b00;
        w_alu_op        = 2'b00;
        w_pc_source     = 2'b00;
        w_retire        = 1'b0;
        w_illegal       = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_read  = 1'b1;
                w_alu_src_b = 2'b01;
                w_ir_write  = mem_ready;
                w_pc_write  = mem_ready;
                w_next      = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Branch target is precomputed here into ALUOut
                w_alu_src_b = 2'b11;
                case (op)
                    c_OP_LW, c_OP_SW: w_next = S_MEMADR;
                    c_OP_RTYPE:       w_next = S_EXEC;
                    c_OP_BEQ:         w_next = S_BRANCH;
                    c_OP_J:           w_next = S_JUMP;
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_next      = (op == c_OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                w_mem_read = 1'b1;
                w_i_or_d   = 1'b1;
                w_next     = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
                w_retire     = 1'b1;
            end
            S_MEMWR: begin
                w_mem_write = 1'b1;
                w_i_or_d    = 1'b1;
                w_retire    = mem_ready;
                w_next      = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = 2'b10;
                w_next      = S_RWB;
            end
            S_RWB: begin
                w_reg_write = 1'b1;
                w_reg_dst   = 1'b1;
                w_retire    = 1'b1;
            end
            S_BRANCH: begin
                w_alu_src_a     = 1'b1;
                w_alu_op        = 2'b01;
                w_pc_write_cond = 1'b1;
                w_pc_source     = 2'b01;
                w_retire        = 1'b1;
            end
            S_JUMP: begin
                w_pc_write  = 1'b1;
                w_pc_source = 2'b10;
                w_retire    = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Outputs are gated by reset so no memory request leaks out while held
    assign pc_write      = rst_n & w_pc_write;
    assign pc_write_cond = rst_n & w_pc_write_cond;
    assign i_or_d        = rst_n & w_i_or_d;
    assign mem_read      = rst_n & w_mem_read;
    assign mem_write     = rst_n & w_mem_write;
    assign ir_write      = rst_n & w_ir_write;
    assign mem_to_reg    = rst_n & w_mem_to_reg;
    assign reg_dst       = rst_n & w_reg_dst;
    assign reg_write     = rst_n & w_reg_write;
    assign alu_src_a     = rst_n & w_alu_src_a;
    assign alu_src_b     = rst_n ? w_alu_src_b : 2'b00;
    assign alu_op        = rst_n ? w_alu_op    : 2'b00;
    assign pc_source     = rst_n ? w_pc_source : 2'b00;
    assign retire        = rst_n & w_retire;
    assign illegal       = rst_n & w_illegal;
    assign state         = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl
// Brief    : Directed plus randomized checking of multicycle_ctrl against an
//            instruction-recipe reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, retire, illegal;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    int errors = 0;
    int checks = 0;

    multicycle_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .retire(retire), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] c_R = 6'b000000, c_LW = 6'b100011, c_SW = 6'b101011;
    localparam logic [5:0] c_BEQ = 6'b000100, c_J = 6'b000010;

    // Reference model: an instruction is a list of state codes it walks through
    int  m_st, m_idx, m_cyc, m_stalls, m_nret, m_nill;
    int  m_seq[$];
    bit  m_legal;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] exp_outs(int s, bit mr, bit rn, logic [5:0] o);
        logic pw = 0, pwc = 0, iod = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0;
        logic rdst = 0, rw = 0, asa = 0, ret = 0, ill = 0;
        logic [1:0] asb = 0, aop = 0, psrc = 0;
        case (s)
            0: begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
            1: begin asb = 2'b11; ill = !(o inside {c_R, c_LW, c_SW, c_BEQ, c_J}); end
            2: begin asa = 1; asb = 2'b10; end
            3: begin mrd = 1; iod = 1; end
            4: begin rw = 1; m2r = 1; ret = 1; end
            5: begin mwr = 1; iod = 1; ret = mr; end
            6: begin asa = 1; aop = 2'b10; end
            7: begin rw = 1; rdst = 1; ret = 1; end
            8: begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; ret = 1; end
            9: begin pw = 1; psrc = 2'b10; ret = 1; end
            default: ;
        endcase
        if (!rn) return '0;
        return {pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, psrc, ret, ill};
    endfunction

    task automatic model_restart();
        m_st = 0; m_idx = 0; m_cyc = 0; m_stalls = 0; m_nret = 0; m_nill = 0;
        m_seq = {0, 1}; m_legal = 1'b0;
    endtask

    task automatic model_step(input bit mr, input bit rn, input logic [5:0] o);
        if (!rn) begin
            model_restart();
            return;
        end
        m_cyc++;
        if (m_st == 1) begin
            m_legal = 1'b1;
            case (o)
                c_LW:    m_seq = {0, 1, 2, 3, 4};
                c_SW:    m_seq = {0, 1, 2, 5};
                c_R:     m_seq = {0, 1, 6, 7};
                c_BEQ:   m_seq = {0, 1, 8};
                c_J:     m_seq = {0, 1, 9};
                default: begin m_seq = {0, 1}; m_legal = 1'b0; end
            endcase
        end
        if ((m_st == 0 || m_st == 3 || m_st == 5) && !mr) begin
            m_stalls++;
        end else begin
            m_idx++;
            if (m_idx >= m_seq.size()) begin
                check("instr_cycles", m_cyc, m_seq.size() + m_stalls);
                check("retire_count", m_nret, m_legal ? 1 : 0);
                check("illegal_count", m_nill, m_legal ? 0 : 1);
                model_restart();
            end else begin
                m_st = m_seq[m_idx];
            end
        end
    endtask

    task automatic run_cycle(input bit mr);
        mem_ready = mr;
        @(negedge clk);
        check("state", state, m_st);
        check("outputs", {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                          mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                          pc_source, retire, illegal},
              exp_outs(m_st, mr, rst_n, op));
        check("rd_wr_exclusive", mem_read & mem_write, 0);
        check("retire_illegal_exclusive", retire & illegal, 0);
        m_nret += retire;
        m_nill += illegal;
        @(posedge clk);
        model_step(mr, rst_n, op);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; op = c_R; mem_ready = 1'b0;
        model_restart();
        @(posedge clk); #1;

        // Reset held, then idle fetch with slow memory
        repeat (3) run_cycle(1'b0);
        rst_n = 1'b1;
        repeat (2) run_cycle(1'b0);

        // lw with fast memory
        op = c_LW;
        repeat (5) run_cycle(1'b1);

        // sw with a 2-cycle write stall
        op = c_SW;
        repeat (3) run_cycle(1'b1);
        run_cycle(1'b0); run_cycle(1'b0); run_cycle(1'b1);

        // R-format then beq back to back
        op = c_R;
        repeat (4) run_cycle(1'b1);
        op = c_BEQ;
        repeat (3) run_cycle(1'b1);

        // Unsupported opcode
        op = 6'b111111;
        repeat (2) run_cycle(1'b1);

        // Reset in the middle of a stalled load read
        op = c_LW;
        repeat (3) run_cycle(1'b1);
        run_cycle(1'b0);
        check("in_memrd", state, 3);
        rst_n = 1'b0;
        run_cycle(1'b0);
        rst_n = 1'b1;
        op = c_J;
        repeat (3) run_cycle(1'b1);

        // Randomized instruction mix with random memory latency and rare resets
        for (int i = 0; i < 600; i++) begin
            if (m_idx == 0) begin
                case ($urandom_range(0, 5))
                    0: op = c_R;
                    1: op = c_LW;
                    2: op = c_SW;
                    3: op = c_BEQ;
                    4: op = c_J;
                    default: op = 6'($urandom_range(0, 63));
                endcase
            end
            rst_n = ($urandom_range(0, 79) != 0);
            run_cycle($urandom_range(0, 2) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Moore-style main controller for the multi-cycle MIPS datapath. It sequences a shared memory, ALU, register file and PC through fetch, decode, execute, memory and write-back steps for R-format, lw, sw, beq and j instructions. Memory accesses use a ready handshake, so the controller stalls on slow memory. It replaces the single-cycle main control decode. The datapath's existing ALU-control decode still consumes `alu_op`.

## Interface
Parameters: none. Opcodes are fixed: R-format 000000, lw 100011, sw 101011, beq 000100, j 000010.

Ports (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  reset; synchronous, active-low
- op  in  6  opcode from instruction register (IR[31:26]), sampled in DECODE
- mem_ready  in  1  memory completes current read/write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load qualified by ALU zero (beq)
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- mem_to_reg  out  1  register write data: 0 = ALUOut, 1 = MDR
- reg_dst  out  1  destination: 0 = rt, 1 = rd
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  00 = B, 01 = constant 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- alu_op  out  2  00 = add, 01 = subtract, 10 = use funct field
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- retire  out  1  one-cycle pulse in final cycle of each legal instruction
- illegal  out  1  one-cycle pulse when an unsupported opcode is decoded
- state  out  4  current state encoding, for debug/verification

## Operation
States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9. Codes 10–15 are unreachable and go to FETCH. All listed outputs not named for a state are 0.

- **FETCH:** mem_read=1, alu_src_b=01. ir_write and pc_write follow mem_ready (asserted only when mem_ready=1). Next state is DECODE on mem_ready, otherwise stay in FETCH.
- **DECODE:** alu_src_b=11, alu_op=00. Next state by op:
  - lw or sw: MEMADR
  - R-format: EXEC
  - beq: BRANCH
  - j: JUMP
  - other opcodes: FETCH with illegal=1.
- **MEMADR:** alu_src_a=1, alu_src_b=10. Next state is MEMRD if op=lw, else MEMWR.
- **MEMRD:** mem_read=1, i_or_d=1. Next state is MEMWB on mem_ready, otherwise stay.
- **MEMWB:** reg_write=1, mem_to_reg=1, reg_dst=0, retire=1. Next state is FETCH.
- **MEMWR:** mem_write=1, i_or_d=1. retire follows mem_ready. Next state is FETCH on mem_ready, otherwise stay.
- **EXEC:** alu_src_a=1, alu_src_b=00, alu_op=10. Next state is RWB.
- **RWB:** reg_write=1, reg_dst=1, retire=1. Next state is FETCH.
- **BRANCH:** alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01, retire=1. Next state is FETCH.
- **JUMP:** pc_write=1, pc_source=10, retire=1. Next state is FETCH.

Constraints:
- op is read only in DECODE and MEMADR. IR is stable there because ir_write=0 outside FETCH.
- At most one of mem_read and mem_write is asserted in any cycle.

## Timing
- Reset: rst_n sampled low at a rising edge sets state=FETCH.
  - While rst_n is low, every output except `state` is forced to 0 combinationally. This prevents spurious memory requests.
  - Reset wins over any pending transition, including mid-MEMWR or mid-MEMRD. The aborted access is dropped; no retire is issued.
- Outputs are combinational from state, plus mem_ready where noted above. There are no output registers.
- Cycle counts with mem_ready held at 1: lw 5, sw 4, R-format 4, beq 3, j 3, illegal 2.
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle. Request signals hold steady through the stall.
- retire and illegal are never asserted in the same cycle.

## Test plan
- **Reset and idle:** hold rst_n=0 for 3 cycles, then release with mem_ready=0.
  - During reset: all outputs 0, state=0.
  - After release: FETCH with mem_read=1, ir_write=0, state stays 0.
- **lw with mem_ready=1:** op=100011.
  - State sequence 0,1,2,3,4,0.
  - reg_write=1 and mem_to_reg=1 only in state 4.
  - retire pulses exactly once; total 5 cycles.
- **sw with 2-cycle memory stall:** mem_ready=0 for the first 2 cycles of MEMWR, then 1.
  - State sequence 0,1,2,5,5,5,0.
  - mem_write=1 for 3 cycles; retire only on the last of them.
- **R-format then beq back-to-back:**
  - R-format: states 0,1,6,7 with alu_op=10 in EXEC and reg_dst=1 in RWB.
  - beq: states 0,1,8 with pc_write_cond=1, alu_op=01, pc_source=01.
- **Illegal opcode:** op=111111.
  - Sequence 0,1,0 with illegal=1 for one cycle in DECODE.
  - No reg_write, mem_write or retire.
- **Reset mid-access:** assert rst_n=0 while in MEMRD with mem_ready=0.
  - Next state=0; no reg_write follows.
  - After release, a j (op=000010) completes in 3 cycles with pc_source=10.
